// File: rtl/reg_dump_engine.sv
// ---------------------------------------------------------------------------
// reg_dump_engine
//
// Walks a contiguous, possibly wrapping range of register-file indices and
// emits each register as a valid/ready beat. The block only reads through
// register-file read port A. It drives no write controls.
//
// Ports
//   Clk       in   clock, rising edge
//   ResetL    in   asynchronous active-low reset
//   Start     in   request a dump (sampled only in IDLE)
//   Abort     in   terminate an in-progress dump
//   FirstReg  in   first index to dump (sampled with Start)
//   LastReg   in   last index to dump (sampled with Start)
//   RA        out  read address to register file port A
//   BusA      in   combinational read data for RA
//   OutData   out  captured register value
//   OutReg    out  index of the register in OutData
//   OutValid  out  OutData/OutReg valid
//   OutReady  in   consumer accepts the beat
//   Busy      out  dump in progress
//   Done      out  one-cycle pulse on normal completion
//
// Build option
//   DUMP_SKIP_XZR_EN  when defined, the top index (the zero register) is
//                     never emitted. The walk steps over it without an
//                     ADDR/SEND pair.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for Start; RA holds its last value
// ADDR  | RA stable for the whole cycle; BusA captured at the cycle end
// SEND  | OutValid high; beat held until OutValid && OutReady
// DONE  | one-cycle Done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module reg_dump_engine #(
  parameter int DATA_W = 64,
  parameter int IDX_W  = 5
) (
  input  logic              Clk,
  input  logic              ResetL,
  input  logic              Start,
  input  logic              Abort,
  input  logic [IDX_W-1:0]  FirstReg,
  input  logic [IDX_W-1:0]  LastReg,
  output logic [IDX_W-1:0]  RA,
  input  logic [DATA_W-1:0] BusA,
  output logic [DATA_W-1:0] OutData,
  output logic [IDX_W-1:0]  OutReg,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              Busy,
  output logic              Done
);

`ifdef DUMP_SKIP_XZR_EN
  localparam bit SKIP_XZR = 1'b1;
`else
  localparam bit SKIP_XZR = 1'b0;
`endif

  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dumpState_e;

  dumpState_e        state, stateNext;
  logic [IDX_W-1:0]  raQ, raNext;
  logic [IDX_W-1:0]  lastQ, lastNext;
  logic [IDX_W-1:0]  outRegQ, outRegNext;
  logic [DATA_W-1:0] outDataQ, outDataNext;
  logic [IDX_W-1:0]  raInc;

  // Index arithmetic wraps naturally at the top index.
  assign raInc = raQ + IDX_W'(1);

  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      state    <= IDLE;
      raQ      <= '0;
      lastQ    <= '0;
      outRegQ  <= '0;
      outDataQ <= '0;
    end else begin
      state    <= stateNext;
      raQ      <= raNext;
      lastQ    <= lastNext;
      outRegQ  <= outRegNext;
      outDataQ <= outDataNext;
    end
  end

  always_comb begin
    stateNext   = state;
    raNext      = raQ;
    lastNext    = lastQ;
    outRegNext  = outRegQ;
    outDataNext = outDataQ;

    case (state)
      IDLE: begin
        // Abort is ignored here, so Start wins over a simultaneous Abort.
        if (Start) begin
          lastNext  = LastReg;
          raNext    = FirstReg;
          stateNext = ADDR;
          if (SKIP_XZR && (FirstReg == IDX_MAX)) begin
            if (LastReg == IDX_MAX) begin
              stateNext = DONE;
            end else begin
              raNext = '0;
            end
          end
        end
      end

      ADDR: begin
        if (Abort) begin
          stateNext = IDLE;
        end else begin
          outDataNext = BusA;
          outRegNext  = raQ;
          stateNext   = SEND;
        end
      end

      SEND: begin
        // Abort takes priority over a handshake in the same cycle.
        if (Abort) begin
          stateNext = IDLE;
        end else if (OutReady) begin
          if (outRegQ == lastQ) begin
            stateNext = DONE;
          end else if (SKIP_XZR && (raInc == IDX_MAX)) begin
            // The top index is stepped over. If it was also the final
            // index, the dump ends with the register just accepted.
            if (lastQ == IDX_MAX) begin
              stateNext = DONE;
            end else begin
              raNext    = '0;
              stateNext = ADDR;
            end
          end else begin
            raNext    = raInc;
            stateNext = ADDR;
          end
        end
      end

      DONE: begin
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign RA       = raQ;
  assign OutData  = outDataQ;
  assign OutReg   = outRegQ;
  assign OutValid = (state == SEND);
  assign Busy     = (state == ADDR) || (state == SEND);
  assign Done     = (state == DONE);

endmodule
